// File: rtl/aqe_prog_loader.sv
// Program loader: assembles a byte stream into 128-bit words and holds the CPU in reset.
// Optional trailer checksum is compiled in with `define AQE_PROG_CHECKSUM_EN.
module aqe_prog_loader #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    input  logic         start,
    input  logic [19:0]  base_addr,
    input  logic [19:0]  word_count,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    output logic         prog_wen,
    output logic [19:0]  prog_waddr,
    output logic [127:0] prog_wdata,
    output logic         load_busy,
    output logic         load_done,
    output logic         cpu_hold_rst_b,
    output logic         chk_err
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef AQE_PROG_CHECKSUM_EN
        CHECK,
`endif
        HOLD,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [19:0]   addr;
    logic [19:0]   total;
    logic [19:0]   wcnt;
    logic [3:0]    bidx;
    logic [119:0]  lanes;
    logic [7:0]    hcnt;
    logic          idle_like;
    logic          go;
    logic          accept;
    logic          last_word;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign go        = start && idle_like;
    assign accept    = byte_valid && byte_ready;
    assign last_word = (wcnt + 20'd1) == total;

`ifdef AQE_PROG_CHECKSUM_EN
    logic [7:0] sum;
    assign byte_ready = (state == COLLECT) || (state == CHECK);
`else
    assign byte_ready = (state == COLLECT);
    assign chk_err    = 1'b0;
`endif

    assign prog_wen       = (state == WRITE);
    assign load_busy      = !idle_like;
    assign load_done      = (state == DONE);
    assign cpu_hold_rst_b = (state == DONE);

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (word_count == 20'd0) ? HOLD : COLLECT;
                end
            end
            COLLECT: begin
                if (accept && bidx == 4'd15) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
`ifdef AQE_PROG_CHECKSUM_EN
                state_nxt = last_word ? CHECK : COLLECT;
`else
                state_nxt = last_word ? HOLD : COLLECT;
`endif
            end
`ifdef AQE_PROG_CHECKSUM_EN
            CHECK: begin
                if (byte_valid) begin
                    state_nxt = HOLD;
                end
            end
`endif
            HOLD: begin
                if (hcnt == HOLD_LAST) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            addr       <= '0;
            total      <= '0;
            wcnt       <= '0;
            bidx       <= '0;
            lanes      <= '0;
            hcnt       <= '0;
            prog_waddr <= '0;
            prog_wdata <= '0;
`ifdef AQE_PROG_CHECKSUM_EN
            sum        <= '0;
            chk_err    <= 1'b0;
`endif
        end else begin
            if (go) begin
                addr  <= base_addr;
                total <= word_count;
                wcnt  <= '0;
                bidx  <= '0;
                hcnt  <= '0;
`ifdef AQE_PROG_CHECKSUM_EN
                sum     <= '0;
                chk_err <= 1'b0;
`endif
            end
            if (state == COLLECT && accept) begin
                bidx <= bidx + 4'd1;
`ifdef AQE_PROG_CHECKSUM_EN
                sum <= sum + byte_data;
`endif
                // Last lane goes straight to the write register.
                if (bidx == 4'd15) begin
                    prog_waddr <= addr;
                    prog_wdata <= {byte_data, lanes};
                end else begin
                    lanes[{bidx, 3'b000} +: 8] <= byte_data;
                end
            end
            if (state == WRITE) begin
                addr <= addr + 20'd1;
                wcnt <= wcnt + 20'd1;
                hcnt <= '0;
            end
`ifdef AQE_PROG_CHECKSUM_EN
            if (state == CHECK && byte_valid) begin
                chk_err <= (byte_data != sum);
            end
`endif
            if (state == HOLD) begin
                hcnt <= hcnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_aqe_prog_loader.sv
// Directed bench for aqe_prog_loader; writes captured on the falling edge.
// Checksum scenarios are enabled with `define AQE_PROG_CHECKSUM_EN.
module tb_aqe_prog_loader;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         start;
    logic [19:0]  base_addr;
    logic [19:0]  word_count;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         prog_wen;
    logic [19:0]  prog_waddr;
    logic [127:0] prog_wdata;
    logic         load_busy;
    logic         load_done;
    logic         cpu_hold_rst_b;
    logic         chk_err;

    int           nvec = 0;
    int           errs = 0;
    logic [7:0]   tsum;
    logic [19:0]  wa_q[$];
    logic [127:0] wd_q[$];

    always #5 clk = ~clk;

    aqe_prog_loader #(.HOLD_CYCLES(16)) dut (
        .pll_core_cpuclk(clk),
        .pad_cpu_rst_b(rst_b),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .prog_wen(prog_wen),
        .prog_waddr(prog_waddr),
        .prog_wdata(prog_wdata),
        .load_busy(load_busy),
        .load_done(load_done),
        .cpu_hold_rst_b(cpu_hold_rst_b),
        .chk_err(chk_err)
    );

    always @(negedge clk) begin
        if (prog_wen) begin
            wa_q.push_back(prog_waddr);
            wd_q.push_back(prog_wdata);
        end
    end

    function automatic logic [127:0] ramp(input logic [7:0] b);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = b + 8'(i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [19:0] a, input logic [19:0] n);
        wa_q.delete();
        wd_q.delete();
        tsum       = 8'h00;
        base_addr  = a;
        word_count = n;
        start      = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if (cpu_hold_rst_b !== 1'b0 || load_done !== 1'b0) begin
            errs++;
            $display("FAIL start_hold: hold_b=%b done=%b, want 0 0",
                     cpu_hold_rst_b, load_done);
        end
        nvec++;
        if (load_busy !== 1'b1) begin
            errs++;
            $display("FAIL start_busy: got %b want 1", load_busy);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap, input bit poke);
        int b;
        repeat (gap) begin
            byte_valid = 1'b0;
            start      = poke;
            tick();
            start = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = d;
        b = 0;
        while (byte_ready !== 1'b1 && b < 50) begin
            tick();
            b++;
        end
        if (b >= 50) begin
            nvec++;
            errs++;
            $display("FAIL byte_timeout: byte_ready=%b want 1", byte_ready);
        end else begin
            tick();
            tsum = tsum + d;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_trailer(input logic [7:0] d);
`ifdef AQE_PROG_CHECKSUM_EN
        send_byte(d, 0, 1'b0);
`else
        byte_data = d;
`endif
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (load_done !== 1'b1 && b < 500) begin
            tick();
            b++;
        end
        nvec++;
        if (load_done !== 1'b1) begin
            errs++;
            $display("FAIL done_timeout: load_done=%b want 1", load_done);
        end
    endtask

    task automatic test_reset();
        rst_b      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        tick();
        tick();
        nvec++;
        if ({prog_wen, byte_ready, load_busy, load_done, chk_err, cpu_hold_rst_b} !== 6'b0) begin
            errs++;
            $display("FAIL rst_flags: got %b want 000000",
                     {prog_wen, byte_ready, load_busy, load_done, chk_err, cpu_hold_rst_b});
        end
        nvec++;
        if (prog_waddr !== 20'h0 || prog_wdata !== 128'h0) begin
            errs++;
            $display("FAIL rst_prog: addr=%h data=%h want 0", prog_waddr, prog_wdata);
        end
        rst_b = 1'b1;
        tick();
        tick();
        nvec++;
        if (cpu_hold_rst_b !== 1'b0 || load_busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_hold: hold_b=%b busy=%b want 0 0", cpu_hold_rst_b, load_busy);
        end
    endtask

    task automatic test_basic();
        int n;
        do_start(20'h00100, 20'd2);
        for (int i = 0; i < 32; i++) send_byte(8'(i), 0, 1'b0);
        nvec++;
        if (prog_wen !== 1'b1) begin
            errs++;
            $display("FAIL basic_wen: got %b want 1", prog_wen);
        end
        tick();
        send_trailer(tsum);
        n = 0;
        while (cpu_hold_rst_b !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        nvec++;
        if (n != 16) begin
            errs++;
            $display("FAIL basic_hold: got %0d cycles want 16", n);
        end
        nvec++;
        if (load_done !== 1'b1 || load_busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_done: done=%b busy=%b want 1 0", load_done, load_busy);
        end
        nvec++;
        if (wa_q.size() != 2) begin
            errs++;
            $display("FAIL basic_nwr: got %0d want 2", wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nvec++;
                if (wa_q[i] !== 20'h00100 + 20'(i) || wd_q[i] !== ramp(8'(16 * i))) begin
                    errs++;
                    $display("FAIL basic_wr%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                             20'h00100 + 20'(i), ramp(8'(16 * i)));
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_start(20'hFFFFF, 20'd2);
        for (int i = 0; i < 32; i++) send_byte(8'h40 + 8'(i), 0, 1'b0);
        tick();
        send_trailer(tsum);
        wait_done();
        nvec++;
        if (wa_q.size() != 2) begin
            errs++;
            $display("FAIL wrap_nwr: got %0d want 2", wa_q.size());
        end else begin
            nvec++;
            if (wa_q[0] !== 20'hFFFFF || wa_q[1] !== 20'h00000) begin
                errs++;
                $display("FAIL wrap_addr: got %h,%h want fffff,00000", wa_q[0], wa_q[1]);
            end
            nvec++;
            if (wd_q[1] !== ramp(8'h50)) begin
                errs++;
                $display("FAIL wrap_data: got %h want %h", wd_q[1], ramp(8'h50));
            end
        end
    endtask

    task automatic test_zero_count();
        int  n;
        bit  seen;
        do_start(20'h00123, 20'd0);
        byte_valid = 1'b1;
        seen = 1'b0;
        n = 0;
        while (load_done !== 1'b1 && n < 100) begin
            if (byte_ready === 1'b1) seen = 1'b1;
            tick();
            n++;
        end
        byte_valid = 1'b0;
        nvec++;
        if (n != 16) begin
            errs++;
            $display("FAIL zero_hold: got %0d cycles want 16", n);
        end
        nvec++;
        if (seen || wa_q.size() != 0) begin
            errs++;
            $display("FAIL zero_quiet: ready_seen=%b writes=%0d want 0 0", seen, wa_q.size());
        end
        nvec++;
        if (chk_err !== 1'b0) begin
            errs++;
            $display("FAIL zero_chk: got %b want 0", chk_err);
        end
    endtask

    task automatic test_reset_mid();
        do_start(20'h00200, 20'd1);
        for (int i = 0; i < 9; i++) send_byte(8'h50 + 8'(i), 0, 1'b0);
        rst_b = 1'b0;
        #2;
        nvec++;
        if ({load_busy, byte_ready, prog_wen, cpu_hold_rst_b} !== 4'b0) begin
            errs++;
            $display("FAIL async_rst: got %b want 0000",
                     {load_busy, byte_ready, prog_wen, cpu_hold_rst_b});
        end
        rst_b = 1'b1;
        tick();
        do_start(20'h00300, 20'd1);
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 0, 1'b0);
        tick();
        send_trailer(tsum);
        wait_done();
        nvec++;
        if (wa_q.size() != 1) begin
            errs++;
            $display("FAIL rmid_nwr: got %0d want 1", wa_q.size());
        end else begin
            nvec++;
            if (wa_q[0] !== 20'h00300 || wd_q[0] !== ramp(8'hA0)) begin
                errs++;
                $display("FAIL rmid_wr: got %h/%h want 00300/%h", wa_q[0], wd_q[0], ramp(8'hA0));
            end
        end
    endtask

    task automatic test_start_ignored();
        do_start(20'h00400, 20'd2);
        base_addr  = 20'h77777;
        word_count = 20'd5;
        for (int i = 0; i < 32; i++) send_byte(8'h80 + 8'(i), $urandom_range(0, 2), 1'b1);
        tick();
        send_trailer(tsum);
        wait_done();
        nvec++;
        if (wa_q.size() != 2) begin
            errs++;
            $display("FAIL ign_nwr: got %0d want 2", wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nvec++;
                if (wa_q[i] !== 20'h00400 + 20'(i) || wd_q[i] !== ramp(8'h80 + 8'(16 * i))) begin
                    errs++;
                    $display("FAIL ign_wr%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                             20'h00400 + 20'(i), ramp(8'h80 + 8'(16 * i)));
                end
            end
        end
    endtask

    task automatic test_checksum();
`ifdef AQE_PROG_CHECKSUM_EN
        do_start(20'h00500, 20'd1);
        for (int i = 0; i < 16; i++) send_byte(8'h01, 0, 1'b0);
        tick();
        send_byte(8'h10, 0, 1'b0);
        wait_done();
        nvec++;
        if (chk_err !== 1'b0) begin
            errs++;
            $display("FAIL chk_good: got %b want 0", chk_err);
        end
        do_start(20'h00500, 20'd1);
        for (int i = 0; i < 16; i++) send_byte(8'h01, 0, 1'b0);
        tick();
        send_byte(8'h11, 0, 1'b0);
        wait_done();
        nvec++;
        if (chk_err !== 1'b1) begin
            errs++;
            $display("FAIL chk_bad: got %b want 1", chk_err);
        end
        do_start(20'h00000, 20'd0);
        nvec++;
        if (chk_err !== 1'b0) begin
            errs++;
            $display("FAIL chk_clear: got %b want 0", chk_err);
        end
        wait_done();
`else
        do_start(20'h00500, 20'd1);
        for (int i = 0; i < 16; i++) send_byte(8'h01, 0, 1'b0);
        tick();
        nvec++;
        if (byte_ready !== 1'b0 || chk_err !== 1'b0) begin
            errs++;
            $display("FAIL no_trailer: ready=%b chk=%b want 0 0", byte_ready, chk_err);
        end
        wait_done();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_count();
        test_reset_mid();
        test_start_ignored();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/aqe_prog_loader.md
AQE_PROG_LOADER -- requirements
Module: aqe_prog_loader

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: number of cycles cpu_hold_rst_b stays low after the final write, before release; legal range 1..255.
REQ-002 pll_core_cpuclk  input  1  clock; all state changes on its rising edge.
REQ-003 pad_cpu_rst_b  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
REQ-005 base_addr  input  20  first 128-bit word address; sampled on an accepted start.
REQ-006 word_count  input  20  number of 128-bit words to load; sampled on an accepted start.
REQ-007 byte_valid  input  1  byte stream valid.
REQ-008 byte_data  input  8  byte stream data.
REQ-009 byte_ready  output  1  byte accepted when byte_valid and byte_ready are both high.
REQ-010 prog_wen  output  1  memory program write strobe.
REQ-011 prog_waddr  output  20  memory program word address.
REQ-012 prog_wdata  output  128  memory program word data.
REQ-013 load_busy  output  1  high in every state except IDLE and DONE.
REQ-014 load_done  output  1  high in DONE.
REQ-015 cpu_hold_rst_b  output  1  active-low hold for CPU reset; low from accepted start until release.
REQ-016 chk_err  output  1  checksum mismatch flag.

Function
REQ-017 States: IDLE, COLLECT, WRITE, HOLD, DONE, plus CHECK when the checksum feature is compiled in.
REQ-018 IDLE/DONE + start: latch base_addr and word_count, clear the byte index and word counter, clear chk_err, drive cpu_hold_rst_b low; go to COLLECT, or to HOLD if word_count==0.
REQ-019 A start pulse in any other state is ignored.
REQ-020 COLLECT: byte_ready=1; each accepted byte goes to lane k (bits 8k+7:8k, k = byte index 0..15); the first byte fills bits 7:0.
REQ-021 The 16th accepted byte moves the FSM to WRITE in the next cycle.
REQ-022 WRITE: lasts exactly one cycle; prog_wen=1 with prog_waddr = current address and prog_wdata = the assembled word; byte_ready=0.
REQ-023 Leaving WRITE: address +1, modulo 2^20 (20'hFFFFF wraps to 0); word counter +1.
REQ-024 Leaving WRITE: if the word counter equals word_count, go to CHECK (feature on) or HOLD (feature off); otherwise go to COLLECT.
REQ-025 prog_wen is never high outside WRITE.
REQ-026 prog_waddr and prog_wdata hold their last values when prog_wen=0.
REQ-027 HOLD: a counter runs HOLD_CYCLES cycles with cpu_hold_rst_b=0, then the FSM goes to DONE.
REQ-028 DONE: cpu_hold_rst_b=1 and load_done=1 until the next accepted start.
REQ-029 byte_ready=0 in IDLE, WRITE, HOLD and DONE; byte_valid in those states is dropped silently.
REQ-030 Byte stalls (byte_valid low) in COLLECT leave all state unchanged; there is no timeout.

Reset
REQ-031 Reset asserted at any time, including mid-load, forces IDLE within the same cycle (asynchronous).
REQ-032 Reset values: prog_wen=0, prog_waddr=0, prog_wdata=0, byte_ready=0, load_busy=0, load_done=0, chk_err=0, cpu_hold_rst_b=0; all counters 0.
REQ-033 cpu_hold_rst_b remains 0 in IDLE after reset until a load completes.
REQ-034 A partially assembled word is discarded by reset and never written.

Configuration
REQ-035 Macro AQE_PROG_CHECKSUM_EN compiles the checksum feature in or out.
REQ-036 Defined: an 8-bit running sum (mod 256) of all data bytes is kept; CHECK accepts one trailer byte (byte_ready=1); chk_err is set if the trailer differs from the sum; the FSM then goes to HOLD.
REQ-037 Defined: chk_err stays set until the next accepted start or reset.
REQ-038 Defined, word_count==0: CHECK is skipped and chk_err stays 0.
REQ-039 Not defined: CHECK state and the running sum are absent, chk_err is tied 0, and no trailer byte is consumed.

Verification
REQ-040 Reset, start with base_addr=0x00100, word_count=2, bytes 0x00..0x1F with no gaps -> two prog_wen pulses: addr 0x00100 data 0x0F0E..0100, then addr 0x00101 data 0x1F1E..1110; cpu_hold_rst_b rises 16 cycles after the second write; load_done=1.
REQ-041 base_addr=0xFFFFF, word_count=2 -> writes at 0xFFFFF then 0x00000.
REQ-042 word_count=0 -> no prog_wen; DONE reached after HOLD_CYCLES; byte_ready never high.
REQ-043 Reset pulsed after byte 9 of word 0, then a new load -> no write of the partial word; the new load starts at byte lane 0.
REQ-044 AQE_PROG_CHECKSUM_EN defined, one word of bytes 0x01 (sum 0x10): trailer 0x10 -> chk_err=0; trailer 0x11 -> chk_err=1, and load_done still reached.
REQ-045 start pulsed during COLLECT, with byte_valid toggled randomly -> start ignored; written data and addresses are unchanged versus a gap-free run.
